// File: rtl/key_pulse_gen_if.sv
// Key pulse generator signal bundle: raw key input plus debounced pulse/level outputs.
interface key_pulse_gen_if;
  logic key_in;
  logic chan;
  logic key_pressed;

  modport master (
    output key_in,
    input  chan,
    input  key_pressed
  );

  modport slave (
    input  key_in,
    output chan,
    output key_pressed
  );
endinterface : key_pulse_gen_if

// File: rtl/key_pulse_gen.sv
// Debounced key-press pulse generator with 2-flop input synchronizer.
// Optional auto-repeat while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  key_pulse_gen_if.slave   key_bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_illegal
    $error("key_pulse_gen: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             key_meta_r;
  logic             key_sync_r;
  logic             chan_r;
  logic             key_pressed_r;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_r;
  // rpt_phase_r is 0 before the first repeat (waits DELAY), 1 afterwards (waits PERIOD)
  logic             rpt_phase_r;
`endif

  // Two-flop synchronizer; idles high so a released key is seen as not pressed
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
    end else begin
      key_meta_r <= key_bus.key_in;
      key_sync_r <= key_meta_r;
    end
  end

  // Debounce FSM with registered pulse and level outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      chan_r        <= 1'b0;
      key_pressed_r <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_cnt_r     <= {RPT_W{1'b0}};
      rpt_phase_r   <= 1'b0;
`endif
    end else begin
      chan_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!key_sync_r) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end

        PRESS_WAIT: begin
          if (key_sync_r) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_r       <= PRESSED;
            chan_r        <= 1'b1;
            key_pressed_r <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_r     <= {RPT_W{1'b0}};
            rpt_phase_r   <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (key_sync_r) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= PRESSED;
`ifdef KEY_AUTOREPEAT_EN
            if ((!rpt_phase_r && (rpt_cnt_r == RPT_DELAY_LAST)) ||
                ( rpt_phase_r && (rpt_cnt_r == RPT_PERIOD_LAST))) begin
              chan_r      <= 1'b1;
              rpt_cnt_r   <= {RPT_W{1'b0}};
              rpt_phase_r <= 1'b1;
            end else begin
              rpt_cnt_r   <= rpt_cnt_r + RPT_W'(1);
            end
`endif
          end
        end

        // Repeat counter is deliberately untouched here so a bounce resumes timing
        RELEASE_WAIT: begin
          if (!key_sync_r) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_LAST) begin
            state_r       <= IDLE;
            key_pressed_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r       <= IDLE;
          cnt_r         <= {CNT_W{1'b0}};
          key_pressed_r <= 1'b0;
        end
      endcase
    end
  end

  assign key_bus.chan        = chan_r;
  assign key_bus.key_pressed = key_pressed_r;

endmodule : key_pulse_gen

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-level time in sys_clk cycles (20 ms at 50 MHz); legal values are >= 2.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the hold time in cycles before the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, giving the interval in cycles between later auto-repeat pulses.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port key_in, input, 1 bit: raw mechanical key, asynchronous to sys_clk, active-low (0 = pressed).
REQ-007 The block SHALL have port chan, output, 1 bit: registered single-cycle press pulse for the VGA mode state machine.
REQ-008 The block SHALL have port key_pressed, output, 1 bit: registered debounced key level (1 = pressed).

Function
REQ-009 The block SHALL pass key_in through a 2-flop synchronizer (key_sync); no other logic samples key_in.
REQ-010 The block SHALL implement states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with a debounce counter wide enough for DEBOUNCE_CYCLES-1.
REQ-011 In IDLE: key_sync=0 -> PRESS_WAIT with counter cleared to 0; otherwise the block SHALL remain in IDLE.
REQ-012 In PRESS_WAIT: key_sync=1 -> IDLE (bounce, no pulse); counter == DEBOUNCE_CYCLES-1 -> PRESSED; otherwise the counter SHALL increment.
REQ-013 On the PRESS_WAIT->PRESSED transition, chan SHALL be 1 for exactly one cycle.
REQ-014 For key_in falling and held stable, chan SHALL be high in the cycle following rising edge number DEBOUNCE_CYCLES+3 after the fall.
REQ-015 In PRESSED: key_sync=1 -> RELEASE_WAIT with counter cleared to 0.
REQ-016 In RELEASE_WAIT: key_sync=0 -> PRESSED with no chan pulse; counter == DEBOUNCE_CYCLES-1 -> IDLE; otherwise the counter SHALL increment.
REQ-017 key_pressed SHALL be 1 from the cycle chan first asserts until the cycle after entering IDLE, and 0 otherwise.
REQ-018 chan SHALL never be high in two consecutive cycles.
REQ-019 Outside the auto-repeat case of REQ-025, chan SHALL be 1 at most once per IDLE->PRESSED cycle.
REQ-020 Any state value other than the four defined states SHALL transition to IDLE on the next edge, with chan=0.

Reset
REQ-021 While sys_rst_n=0, the block SHALL immediately force: state = IDLE, counters = 0, chan = 0, key_pressed = 0, synchronizer flops = 1.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no pulse emitted.
REQ-023 If key_in is low at reset release, the block SHALL treat it as a new press, and chan SHALL fire per REQ-014 counted from the reset release.

Configuration
REQ-024 Macro KEY_AUTOREPEAT_EN SHALL control auto-repeat; when it is undefined, there SHALL be no repeat counter and exactly one chan pulse per debounced press.
REQ-025 With KEY_AUTOREPEAT_EN defined, while in PRESSED a repeat counter SHALL run; chan SHALL pulse after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD cycles.
REQ-026 With KEY_AUTOREPEAT_EN defined, the repeat counter SHALL clear on entry to PRESSED from PRESS_WAIT and SHALL hold its value in RELEASE_WAIT.

Verification
REQ-027 DEBOUNCE_CYCLES=8; key_in falls and is held -> chan=1 for one cycle after edge 11, and key_pressed rises in that same cycle.
REQ-028 DEBOUNCE_CYCLES=8; key_in low for 5 cycles then high -> chan stays 0, key_pressed stays 0, state returns to IDLE.
REQ-029 After a press, key_in bounces high for 3 cycles then low again -> no second chan pulse, and key_pressed stays 1.
REQ-030 Release held high for 8+ cycles, then a second press -> second chan pulse, one per press.
REQ-031 sys_rst_n pulsed low during PRESS_WAIT with key_in held low -> chan=0 during reset, then a pulse 11 edges after release.
REQ-032 KEY_AUTOREPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=10, key held -> pulses at press, press+20 and press+30 cycles.
